// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: valid/ready load/store sequencer for a level-sensitive, big-endian word memory
module mem_access_ctrl #(
  parameter int ADDR_LIMIT = 1024,
  parameter int READ_WAIT = 1,
  parameter int WRITE_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] mem_data
);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR, GAP, RESP} state_t;
  state_t state;
  logic wr_q, sgn_q, err;
  logic [1:0] size_q, k_q;
  logic [15:0] wdata_q, cnt;
  logic [31:0] base, rd_word, lane, load_val, mask, ins, merged;
  assign base = {req_addr[31:2], 2'b00};
  assign err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00) || base + 32'd3 >= 32'(ADDR_LIMIT);
  // lane k of a big-endian word is brought to the top by shifting left 8k bits
  always_comb begin
    lane = rd_word << {k_q, 3'b000};
    load_val = size_q == 2'b00 ? {{24{sgn_q & lane[31]}}, lane[31:24]} :
               size_q == 2'b01 ? {{16{sgn_q & lane[31]}}, lane[31:16]} : rd_word;
    mask = (size_q == 2'b00 ? 32'hFF00_0000 : 32'hFFFF_0000) >> {k_q, 3'b000};
    ins = (size_q == 2'b00 ? {wdata_q[7:0], 24'h0} : {wdata_q, 16'h0}) >> {k_q, 3'b000};
    merged = (mem_data & ~mask) | ins;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      address <= '0;
      write_data <= '0;
      wr_q <= 1'b0;
      sgn_q <= 1'b0;
      size_q <= '0;
      k_q <= '0;
      wdata_q <= '0;
      rd_word <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          wr_q <= req_write;
          sgn_q <= req_signed;
          size_q <= req_size;
          k_q <= req_addr[1:0];
          wdata_q <= req_wdata[15:0];
          if (err) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_err <= 1'b1;
          end else if (req_write && req_size == 2'b10) begin
            state <= WR_SETUP;
            address <= base;
            write_data <= req_wdata;
          end else begin
            state <= RD;
            address <= base;
            mem_read <= 1'b1;
            cnt <= 16'(READ_WAIT - 1);
          end
        end
        RD: if (cnt == 16'd0) begin
          mem_read <= 1'b0;
          rd_word <= mem_data;
          state <= wr_q ? WR_SETUP : GAP;
          if (wr_q) write_data <= merged;
        end else cnt <= cnt - 16'd1;
        WR_SETUP: begin
          state <= WR;
          mem_write <= 1'b1;
          cnt <= 16'(WRITE_HOLD - 1);
        end
        WR: if (cnt == 16'd0) begin
          mem_write <= 1'b0;
          state <= GAP;
        end else cnt <= cnt - 16'd1;
        GAP: begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= wr_q ? 32'h0 : load_val;
        end
        default: begin
          state <= IDLE;
          req_ready <= 1'b1;
          resp_valid <= 1'b0;
          resp_err <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
  end
endmodule
